// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dmem_arbiter                                               |
// | Description : Two-requester round-robin arbiter and sequencer for the    |
// |               single-port, synchronous-read data RAM. Requester 0 is the |
// |               core data port, requester 1 the debug/loader port. One     |
// |               transaction is in flight at a time; RAM read latency is    |
// |               one cycle.                                                 |
// | Ports       : clk, rst_n        clock, asynchronous active-low reset     |
// |               mX_req/we/addr/wdata   requester X command                 |
// |               mX_gnt            1-cycle pulse, command issued to RAM     |
// |               mX_rvalid/rdata   1-cycle read-data pulse and held data    |
// |               ram_en/we/addr/wdata   registered RAM control              |
// |               ram_rdata         RAM data, valid cycle after a read       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                r_state,      w_state_nxt;
  logic                  r_last_grant, w_last_grant_nxt;
  logic                  r_ram_en,     w_ram_en_nxt;
  logic                  r_ram_we,     w_ram_we_nxt;
  logic [ADDR_WIDTH-1:0] r_ram_addr,   w_ram_addr_nxt;
  logic [DATA_WIDTH-1:0] r_ram_wdata,  w_ram_wdata_nxt;
  logic                  r_m0_gnt,     w_m0_gnt_nxt;
  logic                  r_m1_gnt,     w_m1_gnt_nxt;
  logic                  r_m0_rvalid,  w_m0_rvalid_nxt;
  logic                  r_m1_rvalid,  w_m1_rvalid_nxt;
  logic [DATA_WIDTH-1:0] r_m0_rdata,   w_m0_rdata_nxt;
  logic [DATA_WIDTH-1:0] r_m1_rdata,   w_m1_rdata_nxt;
  logic                  w_win_m1;

  // m1 wins when it is the only requester, or when both request and m0 was
  // the last one served. last_grant also names the owner of an in-flight read.
  assign w_win_m1 = m1_req & (~m0_req | ~r_last_grant);

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_ram_en_nxt     = 1'b0;
    w_ram_we_nxt     = 1'b0;
    w_ram_addr_nxt   = r_ram_addr;
    w_ram_wdata_nxt  = r_ram_wdata;
    w_m0_gnt_nxt     = 1'b0;
    w_m1_gnt_nxt     = 1'b0;
    w_m0_rvalid_nxt  = 1'b0;
    w_m1_rvalid_nxt  = 1'b0;
    w_m0_rdata_nxt   = r_m0_rdata;
    w_m1_rdata_nxt   = r_m1_rdata;
    case (r_state)
      IDLE: begin
        if (m0_req || m1_req) begin
          w_ram_en_nxt     = 1'b1;
          w_last_grant_nxt = w_win_m1;
          w_state_nxt      = ISSUE;
          if (w_win_m1) begin
            w_ram_we_nxt    = m1_we;
            w_ram_addr_nxt  = m1_addr;
            w_ram_wdata_nxt = m1_wdata;
            w_m1_gnt_nxt    = 1'b1;
          end else begin
            w_ram_we_nxt    = m0_we;
            w_ram_addr_nxt  = m0_addr;
            w_ram_wdata_nxt = m0_wdata;
            w_m0_gnt_nxt    = 1'b1;
          end
        end
      end
      ISSUE: begin
        // The RAM performs the access at the end of this cycle; only reads
        // need the extra cycle to collect data.
        w_state_nxt = r_ram_we ? IDLE : WAIT;
      end
      WAIT: begin
        w_state_nxt = IDLE;
        if (r_last_grant) begin
          w_m1_rdata_nxt  = ram_rdata;
          w_m1_rvalid_nxt = 1'b1;
        end else begin
          w_m0_rdata_nxt  = ram_rdata;
          w_m0_rvalid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_m0_gnt     <= 1'b0;
      r_m1_gnt     <= 1'b0;
      r_m0_rvalid  <= 1'b0;
      r_m1_rvalid  <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_ram_en     <= w_ram_en_nxt;
      r_ram_we     <= w_ram_we_nxt;
      r_ram_addr   <= w_ram_addr_nxt;
      r_ram_wdata  <= w_ram_wdata_nxt;
      r_m0_gnt     <= w_m0_gnt_nxt;
      r_m1_gnt     <= w_m1_gnt_nxt;
      r_m0_rvalid  <= w_m0_rvalid_nxt;
      r_m1_rvalid  <= w_m1_rvalid_nxt;
      r_m0_rdata   <= w_m0_rdata_nxt;
      r_m1_rdata   <= w_m1_rdata_nxt;
    end
  end

  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign m0_gnt    = r_m0_gnt;
  assign m1_gnt    = r_m1_gnt;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dmem_arbiter                                            |
// | Description : Self-checking bench for dmem_arbiter. Two queue-driven     |
// |               requesters, a behavioural RAM, and a transaction-level     |
// |               model that predicts every grant and read return.           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port synchronous-read RAM with a backdoor load port.
  logic [31:0] mem [256];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_addr = 8'h0;
  logic [31:0] bd_data = 32'h0;
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          dly;
  } txn_t;

  txn_t        q0[$], q1[$];
  int          wait0, wait1, pop0, pop1;
  logic [31:0] ref_mem [256];
  logic [63:0] exp_g[$], obs_g[$], exp_r[$], obs_r[$];
  int          cyc = 0;
  int          m_idle, pend_cyc;
  logic        m_last, pend_who;
  logic [31:0] pend_data, m_rd0, m_rd1;
  int          anom;
  bit          timed_out;
  int          total = 0;
  int          bad = 0;

  // Event word: {cycle[21:0], who, we, addr, data}; who is bit 41.
  function automatic logic [63:0] ev(int c, logic who, logic we, logic [7:0] a, logic [31:0] d);
    return {c[21:0], who, we, a, d};
  endfunction

  function automatic int first_diff(input logic [63:0] a[$], input logic [63:0] b[$]);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    m_idle = cyc; m_last = 1'b1; pend_cyc = -1; m_rd0 = '0; m_rd1 = '0;
    q0.delete(); q1.delete(); pop0 = -1; pop1 = -1; wait0 = 0; wait1 = 0;
  endtask

  task automatic clear_logs();
    exp_g.delete(); obs_g.delete(); exp_r.delete(); obs_r.delete(); anom = 0;
  endtask

  task automatic push0(input logic we, input logic [7:0] a, input logic [31:0] d, input int dly);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.dly = dly;
    if (q0.size() == 0) wait0 = dly;
    q0.push_back(t);
  endtask

  task automatic push1(input logic we, input logic [7:0] a, input logic [31:0] d, input int dly);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.dly = dly;
    if (q1.size() == 0) wait1 = dly;
    q1.push_back(t);
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d; ref_mem[a] = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic drive();
    if (q0.size() != 0 && wait0 == 0) begin
      m0_req = 1'b1; m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
    end else begin
      m0_req = 1'b0;
      if (q0.size() != 0) wait0--;
    end
    if (q1.size() != 0 && wait1 == 0) begin
      m1_req = 1'b1; m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
    end else begin
      m1_req = 1'b0;
      if (q1.size() != 0) wait1--;
    end
  endtask

  // Runs the queued traffic to completion. The model works per transaction:
  // whenever the arbiter is free and someone requests, the winner is the one
  // not served last; its grant lands one cycle later, a read's data three
  // cycles later, and the arbiter is free again two (write) or three (read)
  // cycles after the arbitration cycle.
  task automatic run(input int max_cyc);
    int   n;
    bit   done;
    logic win;
    txn_t t;
    n = 0; done = 0; timed_out = 0;
    while (!done) begin
      drive();
      if (cyc >= m_idle && (m0_req || m1_req)) begin
        win = (m0_req && m1_req) ? ~m_last : m1_req;
        if (win) begin t = q1[0]; pop1 = cyc + 1; end
        else     begin t = q0[0]; pop0 = cyc + 1; end
        exp_g.push_back(ev(cyc + 1, win, t.we, t.addr, t.wdata));
        if (t.we) begin
          ref_mem[t.addr] = t.wdata;
          m_idle = cyc + 2;
        end else begin
          pend_cyc = cyc + 3; pend_who = win; pend_data = ref_mem[t.addr];
          exp_r.push_back(ev(cyc + 3, win, 1'b0, 8'h0, ref_mem[t.addr]));
          m_idle = cyc + 3;
        end
        m_last = win;
      end
      tick();
      if (m0_gnt)    obs_g.push_back(ev(cyc, 1'b0, ram_we, ram_addr, ram_wdata));
      if (m1_gnt)    obs_g.push_back(ev(cyc, 1'b1, ram_we, ram_addr, ram_wdata));
      if (m0_rvalid) obs_r.push_back(ev(cyc, 1'b0, 1'b0, 8'h0, m0_rdata));
      if (m1_rvalid) obs_r.push_back(ev(cyc, 1'b1, 1'b0, 8'h0, m1_rdata));
      if (cyc == pend_cyc) begin
        if (pend_who) m_rd1 = pend_data; else m_rd0 = pend_data;
      end
      if ((m0_gnt && m1_gnt) || (m0_rvalid && m1_rvalid) || (ram_we && !ram_en) ||
          (ram_en !== (m0_gnt | m1_gnt)) || (m0_rdata !== m_rd0) || (m1_rdata !== m_rd1))
        anom++;
      if (pop0 == cyc) begin void'(q0.pop_front()); wait0 = (q0.size() != 0) ? q0[0].dly : 0; end
      if (pop1 == cyc) begin void'(q1.pop_front()); wait1 = (q1.size() != 0) ? q1[0].dly : 0; end
      n++;
      if (q0.size() == 0 && q1.size() == 0 && cyc >= m_idle) done = 1;
      else if (n >= max_cyc) begin timed_out = 1; done = 1; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h33; m0_wdata = 32'hA5A5A5A5;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h44; m1_wdata = 32'h5A5A5A5A;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      preload(i[7:0], v);
    end
    total++;
    if ({ram_en, ram_we, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000", {ram_en, ram_we, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
    end
    total++;
    if ({ram_addr, ram_wdata} !== 40'h0) begin
      bad++; $display("FAIL reset_ram_bus: got %h want 0", {ram_addr, ram_wdata});
    end
    total++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata});
    end
    m0_req = 1'b0; m1_req = 1'b0;
    rst_n = 1'b1;
    model_reset();
    clear_logs();
  endtask

  task automatic test_simultaneous_first();
    clear_logs();
    push0(1'b0, 8'($urandom), $urandom, 0);
    push1(1'b0, 8'($urandom), $urandom, 0);
    run(50);
    total++;
    if (timed_out) begin bad++; $display("FAIL simul_timeout: got timeout want completion"); end
    total++;
    if (first_diff(exp_g, obs_g) != -1) begin
      bad++; $display("FAIL simul_gnt_log: got %0d grants want %0d, first diff %0d", obs_g.size(), exp_g.size(), first_diff(exp_g, obs_g));
    end
    total++;
    if (first_diff(exp_r, obs_r) != -1) begin
      bad++; $display("FAIL simul_rv_log: got %0d returns want %0d, first diff %0d", obs_r.size(), exp_r.size(), first_diff(exp_r, obs_r));
    end
    total++;
    if (obs_g.size() == 0 || obs_g[0][41] !== 1'b0) begin
      bad++; $display("FAIL simul_first_winner: got %0d grants (first who=%b) want m0 first", obs_g.size(), (obs_g.size() != 0) ? obs_g[0][41] : 1'bx);
    end
    total++;
    if (anom !== 0) begin bad++; $display("FAIL simul_protocol: got %0d anomalies want 0", anom); end
  endtask

  task automatic test_single_read();
    int s;
    preload(8'd5, 32'hDEADBEEF);
    clear_logs();
    s = cyc;
    push0(1'b0, 8'd5, $urandom, 0);
    run(50);
    total++;
    if (timed_out || obs_g.size() != 1 || obs_g[0][63:42] !== 22'(s + 1)) begin
      bad++; $display("FAIL single_gnt_timing: got %0d grants at cycle %0d want 1 at %0d", obs_g.size(), (obs_g.size() != 0) ? int'(obs_g[0][63:42]) : -1, s + 1);
    end
    total++;
    if (obs_r.size() != 1 || obs_r[0] !== ev(s + 3, 1'b0, 1'b0, 8'h0, 32'hDEADBEEF)) begin
      bad++; $display("FAIL single_rvalid: got %0d returns first=%h want one at cycle %0d data deadbeef", obs_r.size(), (obs_r.size() != 0) ? obs_r[0] : 64'h0, s + 3);
    end
    total++;
    if (first_diff(exp_g, obs_g) != -1) begin
      bad++; $display("FAIL single_gnt_log: got %0d want %0d", obs_g.size(), exp_g.size());
    end
    total++;
    if (anom !== 0) begin bad++; $display("FAIL single_protocol: got %0d anomalies want 0", anom); end
  endtask

  task automatic test_write_readback();
    clear_logs();
    push1(1'b1, 8'd10, 32'h12345678, 0);
    run(50);
    push0(1'b0, 8'd10, $urandom, 1);
    run(50);
    total++;
    if (timed_out) begin bad++; $display("FAIL wrrd_timeout: got timeout want completion"); end
    total++;
    if (first_diff(exp_g, obs_g) != -1) begin
      bad++; $display("FAIL wrrd_gnt_log: got %0d grants want %0d, first diff %0d", obs_g.size(), exp_g.size(), first_diff(exp_g, obs_g));
    end
    total++;
    if (obs_r.size() != 1 || obs_r[0][41] !== 1'b0 || obs_r[0][31:0] !== 32'h12345678) begin
      bad++; $display("FAIL wrrd_readback: got %0d returns first=%h want one m0 return of 12345678", obs_r.size(), (obs_r.size() != 0) ? obs_r[0] : 64'h0);
    end
    total++;
    if (mem[10] !== 32'h12345678) begin
      bad++; $display("FAIL wrrd_ram: got %h want 12345678", mem[10]);
    end
    total++;
    if (anom !== 0) begin bad++; $display("FAIL wrrd_protocol: got %0d anomalies want 0", anom); end
  endtask

  task automatic test_contention();
    int  n0, n1;
    bit  alt;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      push0(1'($urandom), 8'($urandom_range(0, 15)), $urandom, 0);
      push1(1'($urandom), 8'($urandom_range(0, 15)), $urandom, 0);
    end
    run(200);
    n0 = 0; n1 = 0; alt = 1;
    foreach (obs_g[i]) begin
      if (obs_g[i][41]) n1++; else n0++;
      if (i > 0 && obs_g[i][41] === obs_g[i-1][41]) alt = 0;
    end
    total++;
    if (timed_out) begin bad++; $display("FAIL contention_timeout: got timeout want completion"); end
    total++;
    if (n0 != 4 || n1 != 4) begin bad++; $display("FAIL contention_share: got m0=%0d m1=%0d want 4/4", n0, n1); end
    total++;
    if (!alt) begin bad++; $display("FAIL contention_alternate: got repeated winner want strict alternation"); end
    total++;
    if (first_diff(exp_g, obs_g) != -1) begin
      bad++; $display("FAIL contention_gnt_log: got %0d want %0d, first diff %0d", obs_g.size(), exp_g.size(), first_diff(exp_g, obs_g));
    end
    total++;
    if (first_diff(exp_r, obs_r) != -1) begin
      bad++; $display("FAIL contention_rv_log: got %0d want %0d, first diff %0d", obs_r.size(), exp_r.size(), first_diff(exp_r, obs_r));
    end
    total++;
    if (anom !== 0) begin bad++; $display("FAIL contention_protocol: got %0d anomalies want 0", anom); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [4];
    bit          spacing;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      push0(1'b1, 8'(i), d[i], 0);
    end
    run(100);
    spacing = (obs_g.size() == 4);
    for (int i = 1; i < obs_g.size(); i++)
      if (int'(obs_g[i][63:42]) - int'(obs_g[i-1][63:42]) != 2) spacing = 0;
    total++;
    if (timed_out || !spacing) begin
      bad++; $display("FAIL b2b_spacing: got %0d grants (timeout=%0d) want 4 grants 2 cycles apart", obs_g.size(), timed_out);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[i] !== d[i]) begin bad++; $display("FAIL b2b_ram[%0d]: got %h want %h", i, mem[i], d[i]); end
    end
    total++;
    if (obs_r.size() != 0 || anom !== 0) begin
      bad++; $display("FAIL b2b_protocol: got %0d returns %0d anomalies want 0/0", obs_r.size(), anom);
    end
  endtask

  task automatic test_random();
    clear_logs();
    for (int i = 0; i < 20; i++) begin
      push0(1'($urandom), 8'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3));
      push1(1'($urandom), 8'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3));
    end
    run(2000);
    total++;
    if (timed_out) begin bad++; $display("FAIL random_timeout: got timeout want completion"); end
    total++;
    if (first_diff(exp_g, obs_g) != -1) begin
      bad++; $display("FAIL random_gnt_log: got %0d want %0d, first diff %0d", obs_g.size(), exp_g.size(), first_diff(exp_g, obs_g));
    end
    total++;
    if (first_diff(exp_r, obs_r) != -1) begin
      bad++; $display("FAIL random_rv_log: got %0d want %0d, first diff %0d", obs_r.size(), exp_r.size(), first_diff(exp_r, obs_r));
    end
    total++;
    if (anom !== 0) begin bad++; $display("FAIL random_protocol: got %0d anomalies want 0", anom); end
  endtask

  task automatic test_reset_midop();
    bit g;
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'd20; m1_wdata = $urandom;
    g = 0;
    for (int i = 0; i < 10 && !g; i++) begin
      tick();
      if (m1_gnt) g = 1;
    end
    total++;
    if (!g) begin bad++; $display("FAIL midrst_gnt: got no m1_gnt want one within 10 cycles"); end
    m1_req = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== 110'h0) begin
      bad++; $display("FAIL midrst_async_clear: got addr=%h m0_rdata=%h m1_rdata=%h want all 0", ram_addr, m0_rdata, m1_rdata);
    end
    tick();
    total++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
      bad++; $display("FAIL midrst_dropped_read: got rvalid=%b rdata=%h want 0/0", m1_rvalid, m1_rdata);
    end
    rst_n = 1'b1;
    model_reset();
    clear_logs();
    push0(1'b0, 8'd20, $urandom, 0);
    push1(1'b0, 8'd21, $urandom, 0);
    run(50);
    total++;
    if (timed_out || obs_g.size() == 0 || obs_g[0][41] !== 1'b0) begin
      bad++; $display("FAIL midrst_first_after: got %0d grants (timeout=%0d) want m0 granted first", obs_g.size(), timed_out);
    end
    total++;
    if (first_diff(exp_r, obs_r) != -1) begin
      bad++; $display("FAIL midrst_rv_log: got %0d want %0d, first diff %0d", obs_r.size(), exp_r.size(), first_diff(exp_r, obs_r));
    end
    total++;
    if (anom !== 0) begin bad++; $display("FAIL midrst_protocol: got %0d anomalies want 0", anom); end
  endtask

  initial begin
    test_reset();
    test_simultaneous_first();
    test_single_read();
    test_write_readback();
    test_contention();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port, synchronous-read data RAM behind the core's load/store path.
- Requester 0 is the core data port. Requester 1 is the debug/loader port used to preload or inspect data memory at run time.
- Round-robin arbitration; one transaction in flight at a time.
- Registered RAM control with fixed 1-cycle RAM read latency.

Parameters:
- ADDR_WIDTH, 8, word-address width of RAM and requester ports (256 words).
- DATA_WIDTH, 32, data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  core request; held with fields stable until m0_gnt seen
- m0_we  in  1  core write (1) / read (0)
- m0_addr  in  ADDR_WIDTH  core word address
- m0_wdata  in  DATA_WIDTH  core write data
- m0_gnt  out  1  1-cycle pulse: core request issued to RAM
- m0_rvalid  out  1  1-cycle pulse: m0_rdata valid
- m0_rdata  out  DATA_WIDTH  core read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_*, for the debug/loader requester
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable (valid only with ram_en)
- ram_addr  out  ADDR_WIDTH  RAM word address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after ram_en && !ram_we

Behaviour:
- Reset is clk / rst_n (asynchronous, active-low). All outputs are registered.
- Reset values:
  - state = IDLE, last_grant = 1 (m0 wins the first contention)
  - ram_en, ram_we, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid = 0
  - ram_addr, ram_wdata, m0_rdata, m1_rdata = 0
- FSM states are IDLE, ISSUE and WAIT.
- IDLE:
  - If any req is high, select a winner. If both are high, the winner is the requester not equal to last_grant.
  - At the clock edge: capture the winner's we/addr/wdata into ram_* regs; set ram_en = 1; set winner gnt = 1; set last_grant = winner; go to ISSUE.
  - If no req is high, stay in IDLE with ram_en = 0.
- ISSUE (ram_en = 1 and the winner's gnt = 1 for exactly this cycle):
  - Next edge clears ram_en, ram_we and gnt.
  - A write goes to IDLE; a read goes to WAIT.
- WAIT:
  - ram_rdata is valid in this cycle.
  - At the edge, register it into the owner's mX_rdata, pulse the owner's mX_rvalid for one cycle, and go to IDLE.
- Timing:
  - Read: arbitration edge E → gnt in cycle E+1 → rvalid/rdata in cycle E+3.
  - Write: RAM written at the end of the ISSUE cycle; next arbitration possible in cycle E+2.
  - Throughput: one write per 2 cycles, one read per 3 cycles.
- Overlap: the rvalid cycle coincides with IDLE, so a new arbitration may happen in the same cycle that rvalid is high.
- Requester contract:
  - req and fields stay stable from assertion until the cycle gnt = 1.
  - The requester deasserts req at the edge ending the gnt cycle.
  - If req is still high in the following IDLE cycle, it is treated as a new request.
- The non-owner's rdata holds its previous value; rvalid never pulses for writes.
- m0_gnt and m1_gnt are never high in the same cycle; neither are m0_rvalid and m1_rvalid.
- Requests arriving during ISSUE or WAIT wait for IDLE. No request is lost while req stays high.
- Starvation-free: with both requesters continuously requesting, grants strictly alternate.
- ram_addr and ram_wdata hold their values when ram_en = 0; ram_we is 0 whenever ram_en is 0.
- Reset mid-operation:
  - All outputs clear immediately and the FSM returns to IDLE.
  - An in-flight read is dropped (no rvalid).
  - An ISSUE-cycle write is aborted if reset asserts before the clock edge.
- Address range: the address is passed through unmodified; out-of-range detection is the requester's job.

Test Plan:
- Single m0 read: preload RAM[5] = 0xDEADBEEF; m0_req = 1, we = 0, addr = 5 → m0_gnt one cycle after the request edge, m0_rvalid two cycles later with m0_rdata = 0xDEADBEEF; m1 outputs stay 0.
- m1 write then m0 read-back: m1 writes 0x12345678 to addr 10 → m1_gnt, ram_we = 1 for 1 cycle, no rvalid; m0 reads addr 10 → m0_rdata = 0x12345678.
- Simultaneous first requests out of reset: m0 and m1 both read → m0 granted first (last_grant reset = 1), then m1; rvalids in that order, never overlapping.
- Continuous contention for 8 transactions: both req held high, new transaction on each gnt → grants alternate m0, m1, m0…; each requester gets exactly 4.
- Back-to-back writes from m0 to addresses 0..3 → a gnt every 2 cycles; RAM contents match the written data.
- Reset asserted during WAIT of an m1 read → all outputs 0 asynchronously, no m1_rvalid; after release an m0 read completes normally and is granted first.
